// File: rtl/xc_aessub_pkg.sv
// Shared constants and GF(2^8) helpers for the XCrypto AES SubBytes unit.
package xc_aessub_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned STEP_W = 2;

    localparam logic [BYTE_W-1:0] GF_POLY   = 8'h1b;
    localparam logic [BYTE_W-1:0] AFF_FWD_C = 8'h63;
    localparam logic [BYTE_W-1:0] AFF_INV_C = 8'h05;

    localparam logic FAST_DEFAULT = 1'b1;

    // Multiply by x modulo the AES polynomial.
    function automatic logic [BYTE_W-1:0] gf_xtime(input logic [BYTE_W-1:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Shift-and-add field multiply; fixed structure, no data-dependent depth.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] acc;
        logic [BYTE_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Field inverse as a^254 = a^2*a^4*...*a^128; maps 0 to 0 without a special case.
    function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] sq;
        logic [BYTE_W-1:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Forward affine: a ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [BYTE_W-1:0] aff_fwd(input logic [BYTE_W-1:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ AFF_FWD_C;
    endfunction

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [BYTE_W-1:0] aff_inv(input logic [BYTE_W-1:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ AFF_INV_C;
    endfunction

endpackage

// File: rtl/xc_aessub_sbox.sv
// Combinational forward/inverse AES S-box sharing one field inverter.
module xc_aessub_sbox
    import xc_aessub_pkg::*;
(
    input  logic [7:0] x,
    input  logic       enc,
    output logic [7:0] y
);

    logic [BYTE_W-1:0] inv_in;
    logic [BYTE_W-1:0] inv_out;

    // Pre-affine for decrypt, inverter, post-affine for encrypt.
    always_comb begin
        inv_in  = enc ? x : aff_inv(x);
        inv_out = gf_inv(inv_in);
        y       = enc ? aff_fwd(inv_out) : inv_out;
    end

endmodule

// File: rtl/xc_aessub.sv
// XCrypto lightweight AES SubBytes/InvSubBytes functional unit.
module xc_aessub
    import xc_aessub_pkg::*;
#(
    parameter logic FAST = FAST_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_data,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);

    logic [BYTE_W-1:0] x0;
    logic [BYTE_W-1:0] x1;
    logic [BYTE_W-1:0] x2;
    logic [BYTE_W-1:0] x3;

    // ShiftRows-friendly byte gather, gated so idle operands never reach an S-box.
    assign x0 = rs1[7:0]   & {8{valid}};
    assign x1 = rs1[15:8]  & {8{valid}};
    assign x2 = rs2[23:16] & {8{valid}};
    assign x3 = rs2[31:24] & {8{valid}};

    logic unused_ops;
    assign unused_ops = ^{rs1[31:16], rs2[15:0]};

    if (FAST) begin : g_fast

        logic [BYTE_W-1:0] y0;
        logic [BYTE_W-1:0] y1;
        logic [BYTE_W-1:0] y2;
        logic [BYTE_W-1:0] y3;

        xc_aessub_sbox u_sbox0 (.x(x0), .enc(enc), .y(y0));
        xc_aessub_sbox u_sbox1 (.x(x1), .enc(enc), .y(y1));
        xc_aessub_sbox u_sbox2 (.x(x2), .enc(enc), .y(y2));
        xc_aessub_sbox u_sbox3 (.x(x3), .enc(enc), .y(y3));

        // Single-cycle result, zeroed while idle so S(0) never appears.
        assign ready  = valid;
        assign result = valid ? {y3, y2, y1, y0} : 32'h0;

        logic unused_state;
        assign unused_state = ^{clock, reset, flush, flush_data};

    end else begin : g_slow

        logic [STEP_W-1:0] fsm_q;
        logic [STEP_W-1:0] fsm_d;
        logic [BYTE_W-1:0] b0_q;
        logic [BYTE_W-1:0] b0_d;
        logic [BYTE_W-1:0] b1_q;
        logic [BYTE_W-1:0] b1_d;
        logic [BYTE_W-1:0] b2_q;
        logic [BYTE_W-1:0] b2_d;
        logic [BYTE_W-1:0] sbox_in;
        logic [BYTE_W-1:0] sbox_out;
        logic              ready_c;

        assign ready_c = (fsm_q == 2'd3);

        // Step-indexed byte select into the shared S-box.
        always_comb begin
            sbox_in = x0;
            case (fsm_q)
                2'd0:    sbox_in = x0;
                2'd1:    sbox_in = x1;
                2'd2:    sbox_in = x2;
                default: sbox_in = x3;
            endcase
        end

        xc_aessub_sbox u_sbox (.x(sbox_in), .enc(enc), .y(sbox_out));

        // Step counter and byte capture; flush overrides any op in progress.
        always_comb begin
            fsm_d = fsm_q;
            b0_d  = b0_q;
            b1_d  = b1_q;
            b2_d  = b2_q;
            if (flush) begin
                fsm_d = '0;
                b0_d  = flush_data[7:0];
                b1_d  = flush_data[15:8];
                b2_d  = flush_data[23:16];
            end else begin
                if (valid && (fsm_q == 2'd0)) b0_d = sbox_out;
                if (valid && (fsm_q == 2'd1)) b1_d = sbox_out;
                if (valid && (fsm_q == 2'd2)) b2_d = sbox_out;
                if (valid || ready_c)         fsm_d = fsm_q + 2'd1;
            end
        end

        // State registers with synchronous reset to the flush pattern.
        always_ff @(posedge clock) begin
            if (reset) begin
                fsm_q <= '0;
                b0_q  <= flush_data[7:0];
                b1_q  <= flush_data[15:8];
                b2_q  <= flush_data[23:16];
            end else begin
                fsm_q <= fsm_d;
                b0_q  <= b0_d;
                b1_q  <= b1_d;
                b2_q  <= b2_d;
            end
        end

        assign ready  = ready_c;
        assign result = ready_c ? {sbox_out, b2_q, b1_q, b0_q} : 32'h0;

        logic unused_flush;
        assign unused_flush = ^flush_data[31:24];

    end

endmodule

// File: tb/tb_xc_aessub.sv
// Directed and exhaustive checks of both xc_aessub builds against the FIPS-197 S-box.
module tb_xc_aessub;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_data;

    logic        f_valid;
    logic        f_enc;
    logic [31:0] f_rs1;
    logic [31:0] f_rs2;
    logic        f_ready;
    logic [31:0] f_result;

    logic        s_valid;
    logic        s_enc;
    logic [31:0] s_rs1;
    logic [31:0] s_rs2;
    logic        s_ready;
    logic [31:0] s_result;

    int n_checks = 0;
    int n_errors = 0;

    logic [0:255][7:0] sbox_tab;
    logic [7:0]        isbox_tab [256];

    always #5 clock = ~clock;

    xc_aessub #(.FAST(1'b1)) dut_fast (
        .clock(clock), .reset(reset), .flush(flush), .flush_data(flush_data),
        .valid(f_valid), .rs1(f_rs1), .rs2(f_rs2), .enc(f_enc),
        .ready(f_ready), .result(f_result)
    );

    xc_aessub #(.FAST(1'b0)) dut_slow (
        .clock(clock), .reset(reset), .flush(flush), .flush_data(flush_data),
        .valid(s_valid), .rs1(s_rs1), .rs2(s_rs2), .enc(s_enc),
        .ready(s_ready), .result(s_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issue one multi-cycle op from a negedge; returns result at ready and cycles to ready.
    task automatic slow_run(input logic [31:0] a, input logic [31:0] b, input logic e,
                            output logic [31:0] res, output int lat);
        s_rs1   = a;
        s_rs2   = b;
        s_enc   = e;
        s_valid = 1'b1;
        lat     = 0;
        #1;
        while (!s_ready && lat < 8) begin
            @(negedge clock);
            #1;
            lat++;
        end
        res = s_result;
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic [7:0]  l0, l1, l2, l3;
        logic [31:0] exp;

        sbox_tab = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) isbox_tab[sbox_tab[i]] = 8'(i);

        reset = 1'b1; flush = 1'b0; flush_data = 32'h0;
        f_valid = 1'b0; f_enc = 1'b1; f_rs1 = 32'h0; f_rs2 = 32'h0;
        s_valid = 1'b0; s_enc = 1'b1; s_rs1 = 32'h0; s_rs2 = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_slow_ready",  32'(s_ready), 32'h0);
        check("rst_slow_result", s_result,     32'h0);
        check("rst_fast_ready",  32'(f_ready), 32'h0);
        check("rst_fast_result", f_result,     32'h0);

        // Fast build directed vectors.
        f_valid = 1'b1; f_enc = 1'b1; f_rs1 = 32'h0000_0153; f_rs2 = 32'hFF10_0000;
        #1;
        check("fast_enc_ready",  32'(f_ready), 32'h1);
        check("fast_enc_result", f_result,     32'h16CA_7CED);
        f_enc = 1'b0; f_rs1 = 32'h0000_7CED; f_rs2 = 32'h16CA_0000;
        #1;
        check("fast_dec_result", f_result,     32'hFF10_0153);
        f_valid = 1'b0;
        #1;
        check("fast_idle_ready",  32'(f_ready), 32'h0);
        check("fast_idle_result", f_result,     32'h0);

        // Slow build: exact per-cycle timing of two back-to-back ops.
        @(negedge clock);
        s_valid = 1'b1; s_enc = 1'b1; s_rs1 = 32'h0000_0153; s_rs2 = 32'hFF10_0000;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("b2b_ready_c%0d", c), 32'(s_ready), (c % 4 == 3) ? 32'h1 : 32'h0);
            exp = (c == 3) ? 32'h16CA_7CED : (c == 7) ? 32'hFF10_0153 : 32'h0;
            check($sformatf("b2b_result_c%0d", c), s_result, exp);
            if (c == 3) begin
                s_enc = 1'b0; s_rs1 = 32'h0000_7CED; s_rs2 = 32'h16CA_0000;
            end
            @(negedge clock);
        end
        s_valid = 1'b0;
        @(negedge clock);

        // Flush at step 2, with valid still high: flush wins.
        s_valid = 1'b1; s_enc = 1'b1; s_rs1 = 32'h0000_0153; s_rs2 = 32'hFF10_0000;
        repeat (2) @(negedge clock);
        flush = 1'b1; flush_data = 32'hA5A5_A5A5;
        @(negedge clock);
        flush = 1'b0; s_valid = 1'b0;
        #1;
        check("flush_ready", 32'(s_ready), 32'h0);
        check("flush_bytes", {8'h0, dut_slow.g_slow.b2_q, dut_slow.g_slow.b1_q, dut_slow.g_slow.b0_q},
              32'h00A5_A5A5);
        @(negedge clock);
        #1;
        check("flush_hold_ready", 32'(s_ready), 32'h0);
        @(negedge clock);
        slow_run(32'h0, 32'h0, 1'b1, res, lat);
        check("flush_reissue_lat",    32'(lat), 32'd3);
        check("flush_reissue_result", res,      32'h6363_6363);
        s_valid = 1'b0;
        @(negedge clock);

        // Reset at step 1, then a decrypt whose correct answer is all zero.
        s_valid = 1'b1; s_enc = 1'b1; s_rs1 = 32'h0000_0153; s_rs2 = 32'hFF10_0000;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; s_valid = 1'b0;
        #1;
        check("reset_mid_ready", 32'(s_ready), 32'h0);
        @(negedge clock);
        slow_run(32'h0000_6363, 32'h6363_0000, 1'b0, res, lat);
        check("reset_dec_lat",    32'(lat), 32'd3);
        check("reset_dec_result", res,      32'h0);
        s_valid = 1'b0;
        @(negedge clock);

        // Valid dropped at step 1: step and captured byte hold, op then completes.
        s_valid = 1'b1; s_enc = 1'b1; s_rs1 = 32'h0000_0153; s_rs2 = 32'hFF10_0000;
        @(negedge clock);
        s_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall_ready_c%0d", c), 32'(s_ready), 32'h0);
            @(negedge clock);
        end
        slow_run(32'h0000_0153, 32'hFF10_0000, 1'b1, res, lat);
        check("stall_resume_lat",    32'(lat), 32'd2);
        check("stall_resume_result", res,      32'h16CA_7CED);
        s_valid = 1'b0;
        @(negedge clock);

        // Exhaustive: distinct bytes per lane, forward, inverse and round trip.
        f_valid = 1'b1;
        for (int x = 0; x < 256; x++) begin
            l0 = 8'(x); l1 = 8'(x + 1); l2 = 8'(x + 2); l3 = 8'(x + 3);

            exp = {sbox_tab[l3], sbox_tab[l2], sbox_tab[l1], sbox_tab[l0]};
            f_enc = 1'b1; f_rs1 = {16'h0, l1, l0}; f_rs2 = {l3, l2, 16'h0};
            #1;
            check($sformatf("fast_fwd_%02h", l0), f_result, exp);
            slow_run({16'h0, l1, l0}, {l3, l2, 16'h0}, 1'b1, res, lat);
            check($sformatf("slow_fwd_%02h", l0), res, exp);

            exp = {isbox_tab[l3], isbox_tab[l2], isbox_tab[l1], isbox_tab[l0]};
            f_enc = 1'b0; f_rs1 = {16'h0, l1, l0}; f_rs2 = {l3, l2, 16'h0};
            #1;
            check($sformatf("fast_inv_%02h", l0), f_result, exp);
            slow_run({16'h0, l1, l0}, {l3, l2, 16'h0}, 1'b0, res, lat);
            check($sformatf("slow_inv_%02h", l0), res, exp);

            exp = {l3, l2, l1, l0};
            f_enc = 1'b0;
            f_rs1 = {16'h0, sbox_tab[l1], sbox_tab[l0]};
            f_rs2 = {sbox_tab[l3], sbox_tab[l2], 16'h0};
            #1;
            check($sformatf("fast_rt_%02h", l0), f_result, exp);
            slow_run({16'h0, sbox_tab[l1], sbox_tab[l0]}, {sbox_tab[l3], sbox_tab[l2], 16'h0},
                     1'b0, res, lat);
            check($sformatf("slow_rt_%02h", l0), res, exp);
        end
        s_valid = 1'b0;
        f_valid = 1'b0;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
